// File: rtl/regfile_sb.sv
// Parametrised register file with a pending-write scoreboard; reads and stall are combinational, writes/busy update at the edge.
// No backpressure is applied internally: stall is advisory and decode must hold issue_valid low while it is asserted.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] I,
    input  logic            writeEn,
    output logic [XLEN-1:0] out,
    output logic [XLEN-1:0] out1,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic            stall
);

    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            wr_ok, iss_ok;
    logic            haz1, haz2;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREG_W;
    endfunction

    function automatic logic writable(input logic [AW-1:0] a);
        return in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok  = writeEn && writable(rd);
    assign iss_ok = issue_valid && writable(issue_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[rd] <= I;
        end
    end

    // writable() already excludes x0 and out-of-range addresses, so both read to zero.
    always_comb begin
        out = '0;
        if (writable(rs1)) begin
            if ((BYPASS != 0) && wr_ok && (rd == rs1)) out = I;
            else                                       out = mem_q[rs1];
        end
    end

    always_comb begin
        out1 = '0;
        if (writable(rs2)) begin
            if ((BYPASS != 0) && wr_ok && (rd == rs2)) out1 = I;
            else                                       out1 = mem_q[rs2];
        end
    end

    // Set after clear so a new producer supersedes the retiring one; flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok)  busy_d[rd]       = 1'b0;
        if (iss_ok) busy_d[issue_rd] = 1'b1;
        if (flush)  busy_d           = '0;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign haz1  = use_rs1 && in_range(rs1) && busy_q[rs1]
                   && !((BYPASS != 0) && writeEn && (rd == rs1));
    assign haz2  = use_rs2 && in_range(rs2) && busy_q[rs2]
                   && !((BYPASS != 0) && writeEn && (rd == rs2));
    assign stall = haz1 || haz2;
    assign busy  = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1, rs2, rd, issue_rd;
    logic [XLEN-1:0] I, out, out1;
    logic            writeEn, issue_valid, use_rs1, use_rs2, flush;
    logic [NREG-1:0] busy;
    logic            stall;

    int n_chk  = 0;
    int n_fail = 0;

    logic [XLEN-1:0] mem_m  [NREG];
    bit              busy_m [NREG];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .I(I),
        .writeEn(writeEn), .out(out), .out1(out1), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .use_rs1(use_rs1), .use_rs2(use_rs2), .flush(flush),
        .busy(busy), .stall(stall)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] m_read(input int a);
        if (a >= NREG || a == 0) return '0;
        if (writeEn && int'(rd) == a) return I;
        return mem_m[a];
    endfunction

    function automatic logic [NREG-1:0] m_busy();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = busy_m[r];
        return v;
    endfunction

    function automatic logic m_stall();
        logic h1, h2;
        h1 = use_rs1 && busy_m[rs1] && !(writeEn && rd == rs1);
        h2 = use_rs2 && busy_m[rs2] && !(writeEn && rd == rs2);
        return h1 || h2;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < NREG; r++) begin
            mem_m[r]  = '0;
            busy_m[r] = 1'b0;
        end
    endtask

    task automatic idle();
        rs1 = '0; rs2 = '0; rd = '0; I = '0; writeEn = 0;
        issue_valid = 0; issue_rd = '0; use_rs1 = 0; use_rs2 = 0; flush = 0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".out"},   64'(out),   64'(m_read(int'(rs1))));
        check_eq({tag, ".out1"},  64'(out1),  64'(m_read(int'(rs2))));
        check_eq({tag, ".busy"},  64'(busy),  64'(m_busy()));
        check_eq({tag, ".stall"}, 64'(stall), 64'(m_stall()));
    endtask

    // Inputs are held from posedge+1; outputs are checked at the falling edge, then the model advances.
    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        if (writeEn && rd != 0) mem_m[rd] = I;
        for (int r = 1; r < NREG; r++) begin
            if (flush)                                  busy_m[r] = 1'b0;
            else if (issue_valid && int'(issue_rd) == r) busy_m[r] = 1'b1;
            else if (writeEn && int'(rd) == r)           busy_m[r] = 1'b0;
        end
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        m_clear();
        #2;
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_out",  64'(out),  64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int a = 0; a < NREG; a++) begin
            idle(); rs1 = AW'(a); rs2 = AW'(NREG - 1 - a);
            step("rd_all");
        end

        idle(); writeEn = 1; rd = 5; I = 32'hDEADBEEF; step("wr5");
        idle(); rs1 = 5; step("rd5");
        check_eq("rd5_const", 64'(out), 64'hDEADBEEF);
        idle(); writeEn = 1; rd = 0; I = 32'hFFFFFFFF; rs2 = 0; step("wr0");
        idle(); rs2 = 0; step("rd0");
        check_eq("x0_const", 64'(out1), 64'h0);

        idle(); writeEn = 1; rd = 7; I = 32'h12345678; rs1 = 7;
        @(negedge clk);
        check_eq("bypass_const", 64'(out), 64'h12345678);
        step("bypass");

        idle(); issue_valid = 1; issue_rd = 3; step("iss3");
        check_eq("busy3_set", 64'(busy[3]), 64'h1);
        idle(); use_rs1 = 1; rs1 = 3; step("haz3");
        idle(); use_rs1 = 1; rs1 = 3; writeEn = 1; rd = 3; I = 32'h33; step("wb3");
        check_eq("busy3_clr", 64'(busy[3]), 64'h0);

        idle(); issue_valid = 1; issue_rd = 9; step("iss9");
        idle(); issue_valid = 1; issue_rd = 9; writeEn = 1; rd = 9; I = 32'h99; step("coll9");
        check_eq("busy9_keep", 64'(busy[9]), 64'h1);
        idle(); flush = 1; issue_valid = 1; issue_rd = 12; step("flush");
        check_eq("flush_busy", 64'(busy), 64'h0);

        idle(); issue_valid = 1; issue_rd = 4; writeEn = 1; rd = 4; I = 32'hA5A5A5A5; step("setup4");
        idle(); rs1 = 4; use_rs1 = 1;
        #2;
        check_eq("pre_rst_out", 64'(out), 64'hA5A5A5A5);
        reset = 1'b0;
        #1;
        m_clear();
        check_eq("async_out",   64'(out),   64'h0);
        check_eq("async_busy",  64'(busy),  64'h0);
        check_eq("async_stall", 64'(stall), 64'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 500; n++) begin
            rs1         = AW'($urandom_range(0, 15));
            rs2         = AW'($urandom_range(0, 15));
            rd          = AW'($urandom_range(0, 15));
            I           = $urandom;
            writeEn     = ($urandom_range(0, 1) == 1);
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_rd    = AW'($urandom_range(0, 15));
            use_rs1     = ($urandom_range(0, 1) == 1);
            use_rs2     = ($urandom_range(0, 1) == 1);
            flush       = ($urandom_range(0, 31) == 0);
            if (n % 8 == 0) begin
                rs1 = AW'($urandom); rs2 = AW'($urandom); rd = AW'($urandom);
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
